// File: rtl/alu_pkg.sv
// Shared opcode and flag-index constants for the registered N-bit ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_reg_nbit_if.sv
// Operation/result handshake bundle between the operand-select logic and the ALU.
interface alu_reg_nbit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic             input_in_valid;
  logic             output_in_ready;
  logic [2:0]       input_mode_select;
  logic             input_use_acc;
  logic             input_acc_clear;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             output_out_valid;
  logic             input_out_ready;
  logic [WIDTH-1:0] output_result;
  logic [3:0]       output_flags;
  logic [CNT_W-1:0] output_op_count;

  modport master (
    output input_in_valid, input_mode_select, input_use_acc, input_acc_clear,
           input_a, input_b, input_out_ready,
    input  output_in_ready, output_out_valid, output_result, output_flags, output_op_count
  );

  modport slave (
    input  input_in_valid, input_mode_select, input_use_acc, input_acc_clear,
           input_a, input_b, input_out_ready,
    output output_in_ready, output_out_valid, output_result, output_flags, output_op_count
  );
endinterface

// File: rtl/alu_core_nbit.sv
// Combinational WIDTH-bit ALU: eight opcodes, {N, V, C, Z} status flags.
module alu_core_nbit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       mode_select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0] sum;
  logic           carry;
  logic           ovf;

  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (mode_select)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry is the no-borrow bit of A + ~B + 1.
        sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_LT:   result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
    flags[FLAG_N] = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_reg_nbit.sv
// Registered ALU with accumulator, saturating op counter and valid/ready output stage.
module alu_reg_nbit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic           input_clk,
  input logic           input_rst_n,
  alu_reg_nbit_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  assign in_ready = !out_valid_q || bus.input_out_ready;
  assign accept   = bus.input_in_valid && in_ready;
  assign op_a     = bus.input_use_acc ? acc_q : bus.input_a;

  alu_core_nbit #(
    .WIDTH (WIDTH)
  ) u_core (
    .mode_select (bus.input_mode_select),
    .a           (op_a),
    .b           (bus.input_b),
    .result      (core_result),
    .flags       (core_flags)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_d       = acc_q;
    count_d     = count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      flags_d     = core_flags;
      acc_d       = core_result;
      if (count_q != '1) count_d = count_q + CNT_W'(1);
    end else if (bus.input_out_ready) begin
      out_valid_d = 1'b0;
    end
    // A stalled stage ignores all inputs, including the clear.
    if (bus.input_acc_clear && in_ready) acc_d = '0;
  end

  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign bus.output_in_ready  = in_ready;
  assign bus.output_out_valid = out_valid_q;
  assign bus.output_result    = result_q;
  assign bus.output_flags     = flags_q;
  assign bus.output_op_count  = count_q;

endmodule

// File: tb/tb_alu_reg_nbit.sv
// Directed bench for alu_reg_nbit; a second CNT_W=2 instance shadows the stimulus.
module tb_alu_reg_nbit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  alu_reg_nbit_if #(.WIDTH(8), .CNT_W(16)) ifa ();
  alu_reg_nbit_if #(.WIDTH(8), .CNT_W(2))  ifs ();

  assign ifs.input_in_valid    = ifa.input_in_valid;
  assign ifs.input_mode_select = ifa.input_mode_select;
  assign ifs.input_use_acc     = ifa.input_use_acc;
  assign ifs.input_acc_clear   = ifa.input_acc_clear;
  assign ifs.input_a           = ifa.input_a;
  assign ifs.input_b           = ifa.input_b;
  assign ifs.input_out_ready   = ifa.input_out_ready;

  alu_reg_nbit #(.WIDTH(8), .CNT_W(16)) dut (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .bus         (ifa)
  );

  alu_reg_nbit #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .bus         (ifs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic ua, input logic clr,
                       input logic [7:0] a, input logic [7:0] b);
    ifa.input_in_valid    = 1'b1;
    ifa.input_mode_select = op;
    ifa.input_use_acc     = ua;
    ifa.input_acc_clear   = clr;
    ifa.input_a           = a;
    ifa.input_b           = b;
  endtask

  task automatic idle();
    ifa.input_in_valid  = 1'b0;
    ifa.input_use_acc   = 1'b0;
    ifa.input_acc_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    ifa.input_mode_select = OP_ADD;
    ifa.input_a = 8'h00;
    ifa.input_b = 8'h00;
    ifa.input_out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    total++;
    if ({ifa.output_out_valid, ifa.output_result, ifa.output_flags} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b r=%h f=%b want 0/00/0000",
               ifa.output_out_valid, ifa.output_result, ifa.output_flags);
    end
    total++;
    if (ifa.output_op_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", ifa.output_op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ifa.output_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", ifa.output_in_ready);
    end
    exp_cnt = 0;
  endtask

  task automatic test_add();
    tick();
    ifa.input_out_ready = 1'b1;
    drive(OP_ADD, 1'b0, 1'b0, 8'hFF, 8'h01);
    tick();
    idle();
    exp_cnt++;
    total++;
    if (ifa.output_out_valid !== 1'b1 || ifa.output_result !== 8'h00) begin
      bad++;
      $display("FAIL add_result got v=%b r=%h want v=1 r=00",
               ifa.output_out_valid, ifa.output_result);
    end
    total++;
    if (ifa.output_flags !== 4'b0011) begin
      bad++;
      $display("FAIL add_flags got=%b want=0011", ifa.output_flags);
    end
    tick();
    total++;
    if (ifa.output_out_valid !== 1'b0 || ifa.output_result !== 8'h00) begin
      bad++;
      $display("FAIL add_drain got v=%b r=%h want v=0 r=00",
               ifa.output_out_valid, ifa.output_result);
    end
  endtask

  task automatic test_sub();
    drive(OP_SUB, 1'b0, 1'b0, 8'h80, 8'h01);
    tick();
    exp_cnt++;
    total++;
    if (ifa.output_result !== 8'h7F || ifa.output_flags !== 4'b0110) begin
      bad++;
      $display("FAIL sub_ovf got r=%h f=%b want r=7f f=0110",
               ifa.output_result, ifa.output_flags);
    end
    drive(OP_SUB, 1'b0, 1'b0, 8'h01, 8'h02);
    tick();
    idle();
    exp_cnt++;
    total++;
    if (ifa.output_result !== 8'hFF || ifa.output_flags !== 4'b1000) begin
      bad++;
      $display("FAIL sub_borrow got r=%h f=%b want r=ff f=1000",
               ifa.output_result, ifa.output_flags);
    end
  endtask

  task automatic test_logic();
    logic [7:0] exp_r [3];
    logic [3:0] exp_f [3];
    logic [2:0] ops   [3];
    ops[0] = OP_NOT; exp_r[0] = 8'hF0; exp_f[0] = 4'b1000;
    ops[1] = OP_LT;  exp_r[1] = 8'h01; exp_f[1] = 4'b0000;
    ops[2] = OP_EQ;  exp_r[2] = 8'h00; exp_f[2] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b0, 1'b0, 8'h0F, 8'h10);
      tick();
      exp_cnt++;
      total++;
      if (ifa.output_result !== exp_r[i] || ifa.output_flags !== exp_f[i]) begin
        bad++;
        $display("FAIL logic_op%0d got r=%h f=%b want r=%h f=%b", ops[i],
                 ifa.output_result, ifa.output_flags, exp_r[i], exp_f[i]);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back_acc();
    logic [7:0] exp_r [5];
    logic       ua    [5];
    logic       clr   [5];
    logic [7:0] bv    [5];
    ua[0] = 1'b0; clr[0] = 1'b0; bv[0] = 8'd0; exp_r[0] = 8'd5;
    ua[1] = 1'b1; clr[1] = 1'b0; bv[1] = 8'd3; exp_r[1] = 8'd8;
    ua[2] = 1'b1; clr[2] = 1'b0; bv[2] = 8'd3; exp_r[2] = 8'd11;
    ua[3] = 1'b1; clr[3] = 1'b1; bv[3] = 8'd1; exp_r[3] = 8'd12;
    ua[4] = 1'b1; clr[4] = 1'b0; bv[4] = 8'd1; exp_r[4] = 8'd1;
    for (int i = 0; i < 5; i++) begin
      drive(OP_ADD, ua[i], clr[i], 8'd5, bv[i]);
      tick();
      exp_cnt++;
      total++;
      if (ifa.output_result !== exp_r[i] || ifa.output_out_valid !== 1'b1) begin
        bad++;
        $display("FAIL acc_step%0d got r=%0d v=%b want r=%0d v=1", i,
                 ifa.output_result, ifa.output_out_valid, exp_r[i]);
      end
    end
    idle();
    total++;
    if (ifa.output_op_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL acc_count got=%0d want=%0d", ifa.output_op_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    drive(OP_ADD, 1'b0, 1'b0, 8'd1, 8'd2);
    tick();
    exp_cnt++;
    ifa.input_out_ready = 1'b0;
    drive(OP_ADD, 1'b0, 1'b0, 8'd10, 8'd20);
    #1;
    total++;
    if (ifa.output_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_in_ready got=%b want=0", ifa.output_in_ready);
    end
    tick();
    tick();
    total++;
    if (ifa.output_result !== 8'd3 || ifa.output_out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_hold got r=%0d v=%b want r=3 v=1",
               ifa.output_result, ifa.output_out_valid);
    end
    total++;
    if (ifa.output_op_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL stall_count got=%0d want=%0d", ifa.output_op_count, exp_cnt);
    end
    ifa.input_out_ready = 1'b1;
    #1;
    total++;
    if (ifa.output_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_in_ready got=%b want=1", ifa.output_in_ready);
    end
    tick();
    idle();
    exp_cnt++;
    total++;
    if (ifa.output_result !== 8'd30 || ifa.output_op_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL release_result got r=%0d c=%0d want r=30 c=%0d",
               ifa.output_result, ifa.output_op_count, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(OP_ADD, 1'b0, 1'b0, 8'd7, 8'd8);
    tick();
    idle();
    ifa.input_out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({ifa.output_out_valid, ifa.output_result, ifa.output_flags} !== 13'h0 ||
        ifa.output_op_count !== 16'd0) begin
      bad++;
      $display("FAIL async_reset got v=%b r=%h f=%b c=%0d want all zero",
               ifa.output_out_valid, ifa.output_result, ifa.output_flags,
               ifa.output_op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ifa.input_out_ready = 1'b1;
    drive(OP_ADD, 1'b1, 1'b0, 8'hAA, 8'h00);
    tick();
    idle();
    total++;
    if (ifa.output_result !== 8'h00 || ifa.output_flags !== 4'b0001) begin
      bad++;
      $display("FAIL acc_after_reset got r=%h f=%b want r=00 f=0001",
               ifa.output_result, ifa.output_flags);
    end
    tick();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(OP_XOR, 1'b0, 1'b0, 8'(i), 8'h33);
      tick();
      if (i == 1) begin
        total++;
        if (ifs.output_op_count !== 2'd2) begin
          bad++;
          $display("FAIL sat_count_mid got=%0d want=2", ifs.output_op_count);
        end
      end
    end
    idle();
    total++;
    if (ifs.output_op_count !== 2'd3 || ifa.output_op_count !== 16'd5) begin
      bad++;
      $display("FAIL sat_count got n2=%0d n16=%0d want n2=3 n16=5",
               ifs.output_op_count, ifa.output_op_count);
    end
    total++;
    if (ifs.output_result !== 8'h37) begin
      bad++;
      $display("FAIL sat_result got=%h want=37", ifs.output_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back_acc();
    test_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_reg_nbit.md
# alu_reg_nbit

Parametrised, registered successor to the team's 8-function 4-bit ALU. Same opcode set, generalised to WIDTH bits, with status flags, an internal accumulator that can replace operand A, and a one-stage output register behind a valid/ready handshake. It sits between the operand-select logic and the result/display path in the DCE experiment datapath and may stall when downstream is not ready.

## Interface
- WIDTH, default 8: operand and result width, ≥2.
- CNT_W, default 16: width of the accepted-operation counter.

- input_clk  in  1  single clock, all state on rising edge.
- input_rst_n  in  1  asynchronous, active-low reset.
- input_in_valid  in  1  operation presented.
- output_in_ready  out  1  block can accept this cycle.
- input_mode_select  in  3  opcode.
- input_use_acc  in  1  1: operand A = accumulator, input_a ignored.
- input_acc_clear  in  1  zero the accumulator.
- input_a, input_b  in  WIDTH  operands, unsigned for compare, two's complement for overflow.
- output_out_valid  out  1  result register holds an unconsumed result.
- input_out_ready  in  1  downstream consumes result.
- output_result  out  WIDTH  registered result.
- output_flags  out  4  {negative, overflow, carry, zero}, registered with result.
- output_op_count  out  CNT_W  number of accepted operations, saturating.

## Operation
- Opcodes: 000 A+B; 001 A−B; 010 bitwise ~A; 011 A&B; 100 A|B; 101 A^B; 110 (A<B unsigned) zero-extended to WIDTH; 111 (A==B) zero-extended.
- Add/sub computed at WIDTH+1 bits; result = low WIDTH bits, wrap-around.
- carry: add = carry-out; sub = carry-out of A+~B+1 (1 when A≥B unsigned, i.e. no borrow); 0 for all other opcodes.
- overflow: signed overflow for add/sub; 0 otherwise.
- zero = (result==0); negative = result[WIDTH−1]; both for every opcode.
- Accept = input_in_valid && output_in_ready. output_in_ready = !output_out_valid || input_out_ready (pass-through, no bubble).
- On accept: result/flags register loads, output_out_valid←1, accumulator←result, output_op_count+1 (holds at all-ones).
- On input_out_ready && output_out_valid with no accept: output_out_valid←0; result/flags hold their last value.
- While output_out_valid && !input_out_ready: result, flags, accumulator frozen; input ignored.
- input_acc_clear: accumulator←0 at the edge, priority over accept-load. If accept occurs same cycle, operation uses pre-clear accumulator; its result is still output and counted.
- input_use_acc with input_acc_clear=0 and no prior ops: A = 0.

## Timing
- Latency: accept at edge N → result/flags/out_valid visible after edge N, one cycle.
- Throughput: one op per cycle while input_out_ready=1.
- Back-to-back accumulate: op at edge N+1 with use_acc sees result of op accepted at edge N.
- Reset (any time, including mid-stall): output_out_valid=0, output_result=0, output_flags=4'b0000, accumulator=0, output_op_count=0; output_in_ready=1 immediately after reset deasserts; a pending result is discarded.
- output_in_ready is combinational from input_out_ready; no other combinational in→out paths.

## Structure
- Shared package alu_pkg: 3-bit opcode constants (OP_ADD…OP_EQ), flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3).
- Sub-module alu_core_nbit (combinational, WIDTH-parametrised): opcode, A, B → result, flags. Top holds handshake, result register, accumulator, counter.

## Test plan
- WIDTH=8, ADD 8'hFF+8'h01, out_ready=1 → result 8'h00, flags Z=1 C=1 V=0 N=0, out_valid one cycle after accept.
- SUB 8'h80−8'h01 → result 8'h7F, C=1, V=1, N=0; SUB 8'h01−8'h02 → 8'hFF, C=0, N=1.
- Accumulate: ADD 5+0, then use_acc ADD b=3 twice → results 5, 8, 11; acc_clear with simultaneous use_acc ADD b=1 (acc=11) → result 12, next use_acc ADD b=1 → 1.
- Stall: out_ready=0 after one result, drive new op with in_valid → in_ready=0, result held, op_count unchanged; raise out_ready → new op accepted same cycle, result updates next edge.
- Opcodes 010/110/111 with A=8'h0F, B=8'h10 → 8'hF0 (N=1), 8'h01, 8'h00 (Z=1); carry/overflow 0 for all three.
- Assert input_rst_n low while out_valid=1 and stalled → all outputs zero asynchronously; CNT_W=2 with 5 accepts → op_count 3 (saturated).
